// File: rtl/csm_pkg.sv
// Shared sequencer/stack definitions: stack op encodings
// and per-op operand requirements.
package csm_pkg;

   typedef enum logic [2:0] {
      STK_NOP  = 3'd0,
      STK_PUSH = 3'd1,
      STK_POP  = 3'd2,
      STK_REPL = 3'd3,
      STK_RPOP = 3'd4,
      STK_SWAP = 3'd5,
      STK_DUP  = 3'd6,
      STK_OVER = 3'd7
   } stk_op_e;

   localparam int unsigned DEPTH_W = 6;

   // Items that must already be on the stack for the op to proceed
   function automatic logic [DEPTH_W-1:0] stk_need(input stk_op_e op);
      logic [DEPTH_W-1:0] n;
      case (op)
         STK_POP,
         STK_REPL,
         STK_DUP:  n = 6'd1;
         STK_RPOP,
         STK_SWAP,
         STK_OVER: n = 6'd2;
         default:  n = 6'd0;
      endcase
      return n;
   endfunction

   function automatic logic stk_grows(input stk_op_e op);
      return (op == STK_PUSH) || (op == STK_DUP) ||
             (op == STK_OVER);
   endfunction

endpackage

// File: rtl/stack_mem.sv
// Spill storage for stack cells below NOS: pointer-indexed
// synchronous write, registered top-of-memory read.
module stack_mem #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N     = 10
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_top
);

   localparam int unsigned AW = (N < 2) ? 1 : $clog2(N);
   localparam int unsigned PW = $clog2(N + 2);

   logic [WIDTH-1:0] mem_q [N];
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] top_q, top_d;
   logic [AW-1:0]    wr_idx, rd_idx;

   always_comb begin
      ptr_d  = ptr_q;
      top_d  = top_q;
      wr_idx = AW'(ptr_q);
      rd_idx = AW'(ptr_q - PW'(2));
      if (i_clear) begin
         ptr_d = '0;
         top_d = '0;
      end else if (i_push) begin
         ptr_d = ptr_q + PW'(1);
         top_d = i_wdata;
      end else if (i_pop) begin
         ptr_d = ptr_q - PW'(1);
         // Emptied memory presents 0 so NOS reads 0 beyond depth
         top_d = (ptr_q >= PW'(2)) ? mem_q[rd_idx] : '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push && !i_clear) begin
         mem_q[wr_idx] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q <= '0;
         top_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         top_q <= top_d;
      end
   end

   assign o_top = top_q;

endmodule

// File: rtl/data_stack.sv
// Data stack with TOS/NOS registers feeding the ALU, spill
// memory below, and sticky under/overflow flags.
module data_stack
   import csm_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 12
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_clear,
   output logic [WIDTH-1:0] o_tos,
   output logic [WIDTH-1:0] o_nos,
   output logic [5:0]       o_depth,
   output logic             o_underflow,
   output logic             o_overflow
);

   localparam logic [5:0] DMAX = 6'(DEPTH);

   stk_op_e          op;
   logic [WIDTH-1:0] tos_q, tos_d;
   logic [WIDTH-1:0] nos_q, nos_d;
   logic [5:0]       depth_q, depth_d;
   logic             unf_q, unf_d;
   logic             ovf_q, ovf_d;
   logic             mem_push, mem_pop;
   logic [WIDTH-1:0] mem_top;

   assign op = stk_op_e'(i_op);

   always_comb begin
      tos_d    = tos_q;
      nos_d    = nos_q;
      depth_d  = depth_q;
      unf_d    = unf_q;
      ovf_d    = ovf_q;
      mem_push = 1'b0;
      mem_pop  = 1'b0;
      if (i_clear) begin
         tos_d   = '0;
         nos_d   = '0;
         depth_d = '0;
         unf_d   = 1'b0;
         ovf_d   = 1'b0;
      end else if (depth_q < stk_need(op)) begin
         unf_d = 1'b1;
      end else if (stk_grows(op) && depth_q == DMAX) begin
         ovf_d = 1'b1;
      end else begin
         unique case (op)
            STK_PUSH: begin
               tos_d    = i_data;
               nos_d    = tos_q;
               depth_d  = depth_q + 6'd1;
               mem_push = depth_q >= 6'd2;
            end
            STK_POP: begin
               tos_d   = nos_q;
               nos_d   = mem_top;
               depth_d = depth_q - 6'd1;
               mem_pop = depth_q >= 6'd3;
            end
            STK_REPL: tos_d = i_data;
            STK_RPOP: begin
               tos_d   = i_data;
               nos_d   = mem_top;
               depth_d = depth_q - 6'd1;
               mem_pop = depth_q >= 6'd3;
            end
            STK_SWAP: begin
               tos_d = nos_q;
               nos_d = tos_q;
            end
            STK_DUP: begin
               nos_d    = tos_q;
               depth_d  = depth_q + 6'd1;
               mem_push = depth_q >= 6'd2;
            end
            STK_OVER: begin
               tos_d    = nos_q;
               nos_d    = tos_q;
               depth_d  = depth_q + 6'd1;
               mem_push = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tos_q   <= '0;
         nos_q   <= '0;
         depth_q <= '0;
         unf_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         tos_q   <= tos_d;
         nos_q   <= nos_d;
         depth_q <= depth_d;
         unf_q   <= unf_d;
         ovf_q   <= ovf_d;
      end
   end

   stack_mem #(
      .WIDTH (WIDTH),
      .N     (DEPTH - 2)
   ) u_mem (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (mem_push),
      .i_pop   (mem_pop),
      .i_clear (i_clear),
      .i_wdata (nos_q),
      .o_top   (mem_top)
   );

   assign o_tos       = tos_q;
   assign o_nos       = nos_q;
   assign o_depth     = depth_q;
   assign o_underflow = unf_q;
   assign o_overflow  = ovf_q;

endmodule
